// File: rtl/core_pkg.sv
// Shared core constants and pipeline-register bundle types.
// Stage modules import this package.
package core_pkg;

  localparam int INSTR_WIDTH     = 32;
  localparam int CORE_ADDR_WIDTH = 16;

  // addi x0, x0, 0
  localparam logic [INSTR_WIDTH-1:0]     CORE_NOP_INSTR    = 32'h0000_0013;
  localparam logic [CORE_ADDR_WIDTH-1:0] CORE_RESET_VECTOR = '0;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0]     instr;
    logic [CORE_ADDR_WIDTH-1:0] pc;
    logic [CORE_ADDR_WIDTH-1:0] pc_4;
    logic                       valid;
  } if_id_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/EX control, instruction-memory port and IF/ID outputs.
// master = surrounding core (hazard unit, EX, imem); slave = fetch_stage.
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);

  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [DATA_WIDTH-1:0] id_instr;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [ADDR_WIDTH-1:0] id_pc_4;
  logic                  id_valid;
  logic                  misalign_err;
  logic [CNT_WIDTH-1:0]  fetch_count;

  modport master (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, id_instr, id_pc, id_pc_4, id_valid, misalign_err, fetch_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, id_instr, id_pc, id_pc_4, id_valid, misalign_err, fetch_count
  );

endinterface

// File: rtl/pipe_reg_ef.sv
// Pipeline register with enable and flush; reset and flush both load FLUSH_VALUE.
// Priority rst > flush > en; holds when en is low.
module pipe_reg_ef #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= FLUSH_VALUE;
    end else if (flush) begin
      r_q <= FLUSH_VALUE;
    end else if (en) begin
      r_q <= din;
    end
  end

  assign dout = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with PC, IF/ID register, stall, redirect/flush and bubble insertion.
// imem_addr is combinational from PC; an instruction reaches id_instr one edge later.
module fetch_stage
  import core_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = CORE_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(CORE_RESET_VECTOR),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = DATA_WIDTH'(CORE_NOP_INSTR),
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] w_redirect_target;
  logic                  w_advance;
  logic                  r_misalign_err;
  logic [CNT_WIDTH-1:0]  r_fetch_count;

  assign w_advance         = ~bus.redirect_valid & ~bus.stall;
  assign w_pc_plus4        = r_pc + ADDR_WIDTH'(4);
  assign w_redirect_target = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    w_pc_next = r_pc;
    if (bus.redirect_valid) begin
      w_pc_next = w_redirect_target;
    end else if (!bus.stall) begin
      w_pc_next = w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_VECTOR;
      r_misalign_err <= 1'b0;
      r_fetch_count  <= '0;
    end else begin
      r_pc           <= w_pc_next;
      r_misalign_err <= bus.redirect_valid & is_misaligned(bus.redirect_pc[1:0]);
      if (w_advance) begin
        r_fetch_count <= r_fetch_count + CNT_WIDTH'(1);
      end
    end
  end

  // Instruction and valid bit are flushed on redirect; the PC pair keeps its last value.
  logic [DATA_WIDTH:0]     w_iv_din;
  logic [DATA_WIDTH:0]     w_iv_dout;
  logic [2*ADDR_WIDTH-1:0] w_pcs_din;
  logic [2*ADDR_WIDTH-1:0] w_pcs_dout;

  assign w_iv_din  = {bus.imem_rdata, 1'b1};
  assign w_pcs_din = {r_pc, w_pc_plus4};

  pipe_reg_ef #(
    .WIDTH       (DATA_WIDTH + 1),
    .FLUSH_VALUE ({NOP_INSTR, 1'b0})
  ) u_ifid_instr (
    .clk   (clk),
    .rst   (rst),
    .en    (w_advance),
    .flush (bus.redirect_valid),
    .din   (w_iv_din),
    .dout  (w_iv_dout)
  );

  pipe_reg_ef #(
    .WIDTH       (2 * ADDR_WIDTH),
    .FLUSH_VALUE ('0)
  ) u_ifid_pc (
    .clk   (clk),
    .rst   (rst),
    .en    (w_advance),
    .flush (1'b0),
    .din   (w_pcs_din),
    .dout  (w_pcs_dout)
  );

  assign bus.imem_addr    = r_pc;
  assign bus.id_instr     = w_iv_dout[DATA_WIDTH:1];
  assign bus.id_valid     = w_iv_dout[0];
  assign bus.id_pc        = w_pcs_dout[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign bus.id_pc_4      = w_pcs_dout[ADDR_WIDTH-1:0];
  assign bus.misalign_err = r_misalign_err;
  assign bus.fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random control traffic,
// checked against a per-edge reference model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_4;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .CNT_WIDTH(32)) bus ();

  fetch_stage #(
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (32),
    .RESET_VECTOR (16'h0000),
    .NOP_INSTR    (NOP),
    .CNT_WIDTH    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] imem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h1111_1111;
      16'h0004: return 32'h2222_2222;
      16'h0008: return 32'h3333_3333;
      default:  return {~a, a} ^ 32'hA5C3_0F1E;
    endcase
  endfunction

  always_comb bus.imem_rdata = imem_word(bus.imem_addr);

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  logic [15:0] m_pc, m_id_pc, m_id_pc_4;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic rv, input logic [15:0] rpc);
    exp_t e;
    @(negedge clk);
    rst                = r;
    bus.stall          = s;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (r) begin
      m_pc = 16'h0000; m_instr = NOP; m_id_pc = 0; m_id_pc_4 = 0;
      m_valid = 0; m_mis = 0; m_cnt = 0;
    end else if (rv) begin
      m_mis   = (rpc % 4) != 0;
      m_pc    = (rpc / 4) * 4;
      m_instr = NOP;
      m_valid = 0;
    end else if (s) begin
      m_mis = 0;
    end else begin
      m_instr   = imem_word(m_pc);
      m_id_pc   = m_pc;
      m_id_pc_4 = m_pc + 16'd4;
      m_pc      = m_id_pc_4;
      m_valid   = 1;
      m_cnt     = m_cnt + 1;
      m_mis     = 0;
    end
    e.pc = m_pc; e.instr = m_instr; e.id_pc = m_id_pc; e.id_pc_4 = m_id_pc_4;
    e.valid = m_valid; e.mis = m_mis; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0);
  endtask

  // monitor: one expected entry per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("imem_addr",    32'(bus.imem_addr),    32'(e.pc));
        chk("id_instr",     bus.id_instr,          e.instr);
        chk("id_pc",        32'(bus.id_pc),        32'(e.id_pc));
        chk("id_pc_4",      32'(bus.id_pc_4),      32'(e.id_pc_4));
        chk("id_valid",     32'(bus.id_valid),     32'(e.valid));
        chk("misalign_err", 32'(bus.misalign_err), 32'(e.mis));
        chk("fetch_count",  bus.fetch_count,       e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r, s, rv;
    logic [15:0] rpc;
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    m_pc = 0; m_instr = NOP; m_id_pc = 0; m_id_pc_4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    run(3);                        // PCs 0/4/8 fetched, count 3, imem_addr 12
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    run(1);
    step(0, 1, 1, 16'h0040);       // redirect wins over stall
    run(2);
    step(0, 0, 1, 16'h0046);       // misaligned target
    run(2);
    step(0, 0, 1, 16'h0100);       // back-to-back redirects
    step(0, 0, 1, 16'h0203);
    step(0, 0, 1, 16'h0300);
    run(1);
    step(0, 1, 1, 16'h0401);       // redirect then held stall keeps bubble
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    run(1);
    step(0, 0, 1, 16'hFFFC);       // PC wrap
    run(2);
    step(1, 0, 0, 0);
    run(5);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);              // reset mid-stall
    run(2);
    step(1, 0, 1, 16'h0055);       // reset mid-redirect
    run(1);

    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rpc = 16'($urandom);
      step(r, s, rv, rpc);
    end
    step(0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
